// File: rtl/modn_step_counter.sv
// Modulo-M up/down counter with programmable step, synchronous load, wrap/saturate mode
// and registered carry/borrow pulses for cascading. Define MODCNT_WRAPCNT_EN to add the wraps counter.
module modn_step_counter #(
    parameter int M  = 13,
    parameter int B  = $clog2(M),
    parameter int SW = $clog2(M) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          inc,
    input  logic          dec,
    input  logic [SW-1:0] step,
    input  logic          sat,
    input  logic          load,
    input  logic [B-1:0]  load_val,
    output logic [B-1:0]  cnt,
    output logic          carry,
    output logic          borrow,
`ifdef MODCNT_WRAPCNT_EN
    output logic [15:0]   wraps,
`endif
    output logic          at_max,
    output logic          at_zero
);

    localparam int W  = B + 1;
    localparam int CW = (SW > W) ? SW : W;
    localparam logic [W-1:0]  M_W     = W'(M);
    localparam logic [W-1:0]  MAX_W   = W'(M - 1);
    localparam logic [B-1:0]  MAX_B   = B'(M - 1);
    localparam logic [CW-1:0] MAX_CW  = CW'(M - 1);

    logic [B-1:0]  cnt_r;
    logic          carry_r;
    logic          borrow_r;
    logic [CW-1:0] step_ext_s;
    logic [W-1:0]  step_s;
    logic [W-1:0]  cnt_w_s;
    logic [W-1:0]  sum_s;
    logic [W-1:0]  load_w_s;
    logic [B-1:0]  next_cnt_s;
    logic          next_carry_s;
    logic          next_borrow_s;

    // All arithmetic is one bit wider than cnt so cnt + s cannot overflow before the compare.
    assign step_ext_s = CW'(step);
    assign step_s     = (step_ext_s > MAX_CW) ? MAX_W : W'(step_ext_s);
    assign cnt_w_s    = {1'b0, cnt_r};
    assign sum_s      = cnt_w_s + step_s;
    assign load_w_s   = {1'b0, load_val};

    // Next-state selection: load > up > down > hold.
    always_comb begin
        next_cnt_s    = cnt_r;
        next_carry_s  = 1'b0;
        next_borrow_s = 1'b0;
        if (load) begin
            next_cnt_s = (load_w_s > MAX_W) ? MAX_B : load_val;
        end else if (en && inc && !dec) begin
            if (sat) begin
                next_cnt_s = (sum_s > MAX_W) ? MAX_B : sum_s[B-1:0];
            end else if (sum_s >= M_W) begin
                next_cnt_s   = B'(sum_s - M_W);
                next_carry_s = 1'b1;
            end else begin
                next_cnt_s = sum_s[B-1:0];
            end
        end else if (en && dec && !inc) begin
            if (cnt_w_s >= step_s) begin
                next_cnt_s = B'(cnt_w_s - step_s);
            end else if (sat) begin
                next_cnt_s = {B{1'b0}};
            end else begin
                next_cnt_s    = B'(cnt_w_s + M_W - step_s);
                next_borrow_s = 1'b1;
            end
        end else begin
            next_cnt_s = cnt_r;
        end
    end

    // Count and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {B{1'b0}};
            carry_r  <= 1'b0;
            borrow_r <= 1'b0;
        end else begin
            cnt_r    <= next_cnt_s;
            carry_r  <= next_carry_s;
            borrow_r <= next_borrow_s;
        end
    end

`ifdef MODCNT_WRAPCNT_EN
    logic [15:0] wraps_r;

    // Saturating count of wrap events, advancing on the same edge as the pulse.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            wraps_r <= 16'h0000;
        end else if ((next_carry_s || next_borrow_s) && (wraps_r != 16'hFFFF)) begin
            wraps_r <= wraps_r + 16'h0001;
        end else begin
            wraps_r <= wraps_r;
        end
    end

    assign wraps = wraps_r;
`endif

    assign cnt     = cnt_r;
    assign carry   = carry_r;
    assign borrow  = borrow_r;
    assign at_max  = (cnt_r == MAX_B);
    assign at_zero = (cnt_r == {B{1'b0}});

endmodule

// File: tb/tb_modn_step_counter.sv
// Scoreboard bench for modn_step_counter (M=13): an integer reference model queues the
// expected state when stimulus is driven; it is popped and compared after each edge.
module tb_modn_step_counter;

    localparam int M  = 13;
    localparam int B  = $clog2(M);
    localparam int SW = $clog2(M) + 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic          inc;
    logic          dec;
    logic [SW-1:0] step;
    logic          sat;
    logic          load;
    logic [B-1:0]  load_val;
    logic [B-1:0]  cnt;
    logic          carry;
    logic          borrow;
    logic          at_max;
    logic          at_zero;
`ifdef MODCNT_WRAPCNT_EN
    logic [15:0]   wraps;
`endif

    modn_step_counter #(.M(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .inc      (inc),
        .dec      (dec),
        .step     (step),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .carry    (carry),
        .borrow   (borrow),
`ifdef MODCNT_WRAPCNT_EN
        .wraps    (wraps),
`endif
        .at_max   (at_max),
        .at_zero  (at_zero)
    );

    typedef struct {
        int cnt;
        int carry;
        int borrow;
        int wraps;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;
    int   m_wraps  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic cycle(input bit r, input bit e, input bit i, input bit d, input int st,
                         input bit sa, input bit ld, input int lv);
        exp_t x;
        int   s;
        int   t;
        @(negedge clk);
        rst = r; en = e; inc = i; dec = d; step = SW'(st); sat = sa; load = ld; load_val = B'(lv);
        x.carry  = 0;
        x.borrow = 0;
        s = (st > M - 1) ? M - 1 : st;
        if (r) begin
            m_cnt = 0; m_wraps = 0;
        end else if (ld) begin
            m_cnt = (lv > M - 1) ? M - 1 : lv;
            m_wraps = 0;
        end else if (e && i && !d) begin
            t = m_cnt + s;
            if (sa) m_cnt = (t > M - 1) ? M - 1 : t;
            else begin x.carry = (t >= M) ? 1 : 0; m_cnt = t % M; end
        end else if (e && d && !i) begin
            t = m_cnt - s;
            if (sa) m_cnt = (t < 0) ? 0 : t;
            else begin x.borrow = (t < 0) ? 1 : 0; m_cnt = (t + M) % M; end
        end
        if ((x.carry == 1 || x.borrow == 1) && m_wraps < 65535) m_wraps++;
        x.cnt   = m_cnt;
        x.wraps = m_wraps;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        check_val("cnt", 32'(cnt), x.cnt);
        check_val("carry", 32'(carry), x.carry);
        check_val("borrow", 32'(borrow), x.borrow);
        check_val("at_max", 32'(at_max), (x.cnt == M - 1) ? 1 : 0);
        check_val("at_zero", 32'(at_zero), (x.cnt == 0) ? 1 : 0);
`ifdef MODCNT_WRAPCNT_EN
        check_val("wraps", 32'(wraps), x.wraps);
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; inc = 1'b0; dec = 1'b0; step = '0;
        sat = 1'b0; load = 1'b0; load_val = '0;

        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check_val("reset_cnt", 32'(cnt), 0);

        // 13 single steps up: 1..12 then wrap to 0 with carry
        for (int k = 1; k <= 13; k++) begin
            cycle(0, 1, 1, 0, 1, 0, 0, 0);
            if (k == 12) check_val("plan_at_max_12", 32'(at_max), 1);
        end
        check_val("plan_wrap_cnt", 32'(cnt), 0);
        check_val("plan_wrap_carry", 32'(carry), 1);
        cycle(0, 1, 0, 0, 1, 0, 0, 0);
        check_val("carry_one_cycle", 32'(carry), 0);

        // step 5 down, with and without borrow
        cycle(0, 1, 0, 0, 0, 0, 1, 10);
        cycle(0, 1, 0, 1, 5, 0, 0, 0);
        check_val("dec5_from10", 32'(cnt), 5);
        cycle(0, 1, 0, 0, 0, 0, 1, 3);
        cycle(0, 1, 0, 1, 5, 0, 0, 0);
        check_val("dec5_from3", 32'(cnt), 11);
        check_val("dec5_borrow", 32'(borrow), 1);

        // saturate mode, step 4
        cycle(0, 1, 0, 0, 4, 1, 1, 11);
        cycle(0, 1, 1, 0, 4, 1, 0, 0);
        check_val("sat_up", 32'(cnt), 12);
        cycle(0, 1, 0, 0, 4, 1, 1, 2);
        cycle(0, 1, 0, 1, 4, 1, 0, 0);
        check_val("sat_down", 32'(cnt), 0);

        // load clamp, load priority, inc&dec hold, en=0 hold
        cycle(0, 1, 0, 0, 1, 0, 1, 15);
        check_val("load_clamp", 32'(cnt), 12);
        cycle(0, 1, 1, 0, 1, 0, 1, 4);
        check_val("load_wins", 32'(cnt), 4);
        cycle(0, 1, 1, 1, 1, 0, 0, 0);
        check_val("inc_dec_hold", 32'(cnt), 4);
        cycle(0, 0, 1, 0, 1, 0, 0, 0);
        check_val("en0_hold", 32'(cnt), 4);
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        check_val("step0_hold", 32'(cnt), 4);

        // oversized step clamps to M-1; reset overrides inc
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 20, 0, 0, 0);
        check_val("step_clamp", 32'(cnt), 12);
        cycle(1, 1, 1, 0, 1, 0, 0, 0);
        check_val("rst_over_inc", 32'(cnt), 0);

        // 40 increments from 0: three wraps, ends at 1
        for (int k = 0; k < 40; k++) cycle(0, 1, 1, 0, 1, 0, 0, 0);
        check_val("inc40_cnt", 32'(cnt), 1);
`ifdef MODCNT_WRAPCNT_EN
        check_val("inc40_wraps", 32'(wraps), 3);
        cycle(0, 1, 0, 0, 1, 0, 1, 7);
        check_val("load_clears_wraps", 32'(wraps), 0);
`endif

        // random traffic, rare reset and load
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 20), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0), $urandom_range(0, 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
